// File: rtl/audio_stream_pkg.sv
// Shared definitions for the stereo audio stream converters (TX packetizer and RX mono converter).
package audio_stream_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH   = 32;
  localparam int unsigned DEFAULT_SAMPLE_WIDTH = 24;
  localparam int unsigned MAX_DATA_WIDTH       = 64;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND_LEFT  = 2'd1,
    SEND_RIGHT = 2'd2
  } stream_state_e;

  // Zero-extended sample shifted up by the pad width; caller truncates to its TDATA width.
  function automatic logic [MAX_DATA_WIDTH-1:0] left_justify(
    input logic [MAX_DATA_WIDTH-1:0] sample,
    input int unsigned               pad
  );
    return sample << pad;
  endfunction

endpackage

// File: rtl/sample_pair_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed {left, right} sample pairs.
module sample_pair_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push while full is still taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/stereo_sample_to_packet_converter.sv
// Serializes left/right PCM pairs into two left-justified AXI4-Stream beats per frame (TLAST on right).
module stereo_sample_to_packet_converter
  import audio_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    M_AXIS_ACLK,
  input  logic                    M_AXIS_ARESET,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] left_sample,
  input  logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    sample_ready,
  output logic                    sample_overflow,
  output logic                    M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                    M_AXIS_TLAST,
  input  logic                    M_AXIS_TREADY
);

  localparam logic [1:0] ST_IDLE       = IDLE;
  localparam logic [1:0] ST_SEND_LEFT  = SEND_LEFT;
  localparam logic [1:0] ST_SEND_RIGHT = SEND_RIGHT;
  localparam int unsigned PAD          = DATA_WIDTH - SAMPLE_WIDTH;
  localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]                state_q, state_d;
  logic [SAMPLE_WIDTH-1:0]   left_hold_q, left_hold_d;
  logic [SAMPLE_WIDTH-1:0]   right_hold_q, right_hold_d;
  logic                      overflow_q, overflow_d;

  logic [2*SAMPLE_WIDTH-1:0] fifo_head;
  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]             fifo_count;

  sample_pair_fifo #(
    .WIDTH (2*SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (M_AXIS_ACLK),
    .rst_i   (M_AXIS_ARESET),
    .push_i  (sample_valid),
    .wdata_i ({left_sample, right_sample}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Handshake is just TREADY here because TVALID is high in both SEND states.
  always_comb begin
    state_d      = state_q;
    left_hold_d  = left_hold_q;
    right_hold_d = right_hold_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_SEND_LEFT;
        end
      end
      ST_SEND_LEFT: begin
        if (M_AXIS_TREADY) state_d = ST_SEND_RIGHT;
      end
      ST_SEND_RIGHT: begin
        if (M_AXIS_TREADY) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_SEND_LEFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fifo_pop) {left_hold_d, right_hold_d} = fifo_head;
  end

  assign overflow_d = sample_valid && fifo_full && !fifo_pop;

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q      <= ST_IDLE;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      overflow_q   <= overflow_d;
    end
  end

  assign sample_ready    = (fifo_count != CW'(FIFO_DEPTH));
  assign sample_overflow = overflow_q;
  assign M_AXIS_TVALID   = (state_q == ST_SEND_LEFT) || (state_q == ST_SEND_RIGHT);
  assign M_AXIS_TLAST    = (state_q == ST_SEND_RIGHT);

  always_comb begin
    M_AXIS_TDATA = '0;
    if (state_q == ST_SEND_LEFT)
      M_AXIS_TDATA = DATA_WIDTH'(left_justify(MAX_DATA_WIDTH'(left_hold_q), PAD));
    else if (state_q == ST_SEND_RIGHT)
      M_AXIS_TDATA = DATA_WIDTH'(left_justify(MAX_DATA_WIDTH'(right_hold_q), PAD));
  end

endmodule
